gray_updown_counter: RTL and testbench
======================================

# gray_updown_counter

Parametrised successor to the basic Gray-code counter, used for FIFO read/write pointers and other clock-domain-crossing counters. It adds up/down counting, a synchronous parallel load, a selectable wrap-or-saturate mode, a registered binary mirror and a look-ahead next-Gray output. A wrap pulse is also provided. Single clock domain; one instance per pointer.

## Interface
- `NUMBER_OF_BITS`, default 4: counter width in bits, ≥2.
- `RESET_VAL_G`, default all zeros: Gray-coded reset value of `g_count`.
- `SATURATE`, default 0: 0 = wrap at the ends of the range; 1 = hold at the end of the range.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `count_en`, input, 1: step the counter by one this cycle.
- `up_dn`, input, 1: direction; 1 = increment, 0 = decrement.
- `load`, input, 1: synchronous parallel load.
- `load_val_b`, input, `NUMBER_OF_BITS`: binary value to load.
- `g_count`, output, `NUMBER_OF_BITS`: registered Gray count.
- `b_count`, output, `NUMBER_OF_BITS`: registered binary equivalent of `g_count`.
- `g_next`, output, `NUMBER_OF_BITS`: combinational value `g_count` will take at the next edge.
- `wrap`, output, 1: registered one-cycle pulse marking a wrap.
- `at_max`, output, 1: combinational; high when `b_count` is all ones.
- `at_min`, output, 1: combinational; high when `b_count` is all zeros.

## Operation
- The state is held in binary (`b_count`) and Gray (`g_count`) registers, updated together and always consistent: `g_count = b_count ^ (b_count >> 1)`.
- Next binary value `b_nxt`, evaluated in priority order:
  - `load` → `load_val_b`.
  - `count_en & up_dn` → `b_count + 1`, arithmetic mod 2^`NUMBER_OF_BITS`.
  - `count_en & ~up_dn` → `b_count − 1`, arithmetic mod 2^`NUMBER_OF_BITS`.
  - Otherwise → `b_count`.
- `SATURATE=1`:
  - Increment with `at_max` gives `b_nxt = b_count`.
  - Decrement with `at_min` gives `b_nxt = b_count`.
  - No wrap pulse is produced.
- `SATURATE=0`:
  - Increment at all ones → 0, with `wrap` asserted next cycle.
  - Decrement at 0 → all ones, with `wrap` asserted next cycle.
- `load` never produces `wrap`, even when the loaded value equals a wrap target.
- `g_next = bin2gray(b_nxt)`. It accounts for load, direction, saturation and `rst`; when `rst` is high, `g_next = RESET_VAL_G`.
- Single-step property: any count step changes exactly one bit of `g_count`, including across the wrap. This does not hold for `load` or `rst`.
- `up_dn` is ignored when `count_en` is 0.
- `load_val_b` is ignored when `load` is 0.

## Timing
- Reset, sampled at a rising edge while `rst` is high:
  - `g_count = RESET_VAL_G`.
  - `b_count = gray2bin(RESET_VAL_G)`.
  - `wrap = 0`.
  - `rst` overrides `load` and `count_en` in the same cycle.
- Latency is 1 clock from `count_en` or `load` to `g_count`/`b_count`. `g_next` has 0 cycles of latency (combinational).
- `wrap` is high during the cycle in which `g_count` first shows the wrapped value. It is high for exactly one cycle per wrap event.
- Back-to-back wraps produce `wrap` in consecutive cycles. Example: `NUMBER_OF_BITS=2`, alternating direction at the boundary.
- Reset asserted mid-count clears `wrap` on the same edge. The first count after reset release takes effect at the next edge.
- Outputs must not glitch between edges, except the combinational `g_next`, `at_max` and `at_min`.
- No combinational path from `g_count` back to itself other than through the state registers.

## Test plan
- Reset and count up, `NUMBER_OF_BITS=4`: reset, then `count_en=1`, `up_dn=1` for 17 cycles.
  - `g_count`: 0000, 0001, 0011, 0010, …, 1000 (binary 15), 0000, 0001.
  - `wrap` is high only in the cycle showing 0000 after 1000.
  - A scoreboard checks a single bit change per step.
- Count down through zero: from reset, `count_en=1`, `up_dn=0` for 2 cycles.
  - `b_count`: 15, then 14.
  - `g_count`: 1000, then 1001.
  - `wrap` is high in the cycle `b_count=15`.
- Load priority: in one cycle drive `load=1`, `load_val_b=4'd9`, `count_en=1`, `up_dn=1`.
  - Next cycle: `b_count=9`, `g_count=1101`, `wrap=0`.
  - Before the edge: `g_next=1101`.
- Saturate, `SATURATE=1`: load 15, then increment 3 cycles.
  - `b_count` stays 15, `at_max=1`, `wrap` never asserts.
  - Load 0, then decrement: `b_count` stays 0, `at_min=1`.
- Reset mid-operation with `RESET_VAL_G=4'b0011`: counting up at `b_count=7`, assert `rst` with `load=1` for one cycle.
  - Next cycle: `g_count=0011`, `b_count=2`, `wrap=0`.
  - During reset: `g_next=0011`.
- Random regression: 10k cycles of random `count_en`/`up_dn`/`load`/`rst`, compared against a reference model. Check `g_count == bin2gray(b_count)` every cycle.

Source files
------------

// File: rtl/gray_updown_counter.sv
// Up/down Gray-code counter with load, wrap-or-saturate ends, binary mirror and
// look-ahead next-Gray output. Binary and Gray registers always agree.
module gray_updown_counter #(
  parameter int unsigned                  NUMBER_OF_BITS = 4,
  parameter logic [NUMBER_OF_BITS-1:0]    RESET_VAL_G    = '0,
  parameter bit                           SATURATE       = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      count_en,
  input  logic                      up_dn,
  input  logic                      load,
  input  logic [NUMBER_OF_BITS-1:0] load_val_b,
  output logic [NUMBER_OF_BITS-1:0] g_count,
  output logic [NUMBER_OF_BITS-1:0] b_count,
  output logic [NUMBER_OF_BITS-1:0] g_next,
  output logic                      wrap,
  output logic                      at_max,
  output logic                      at_min
);

  function automatic logic [NUMBER_OF_BITS-1:0] bin2gray(input logic [NUMBER_OF_BITS-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [NUMBER_OF_BITS-1:0] gray2bin(input logic [NUMBER_OF_BITS-1:0] g);
    logic [NUMBER_OF_BITS-1:0] b;
    b = g;
    for (int unsigned i = 1; i < NUMBER_OF_BITS; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  localparam logic [NUMBER_OF_BITS-1:0] RESET_VAL_B = gray2bin(RESET_VAL_G);
  localparam logic [NUMBER_OF_BITS-1:0] ONE         = NUMBER_OF_BITS'(1);

  logic [NUMBER_OF_BITS-1:0] b_q, b_d;
  logic [NUMBER_OF_BITS-1:0] g_q, g_d;
  logic                      wrap_q, wrap_d;

  assign at_max = &b_q;
  assign at_min = ~|b_q;

  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    if (load) begin
      b_d = load_val_b;
    end else if (count_en) begin
      if (up_dn) begin
        if (!at_max) begin
          b_d = b_q + ONE;
        end else if (!SATURATE) begin
          b_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          b_d = b_q - ONE;
        end else if (!SATURATE) begin
          b_d    = '1;
          wrap_d = 1'b1;
        end
      end
    end
    // g_next must already reflect a pending reset
    g_d = rst ? RESET_VAL_G : bin2gray(b_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= RESET_VAL_B;
      g_q    <= RESET_VAL_G;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign g_count = g_q;
  assign b_count = b_q;
  assign g_next  = g_d;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: four configurations share one stimulus stream
// and are checked every cycle against an integer reference model.
module tb_gray_updown_counter;

  localparam int NI = 4;

  logic       clk;
  logic       rst, count_en, up_dn, load;
  logic [3:0] lv;

  logic [3:0] g0, b0, n0, g1, b1, n1, g2, b2, n2;
  logic [1:0] g3, b3, n3;
  logic       w0, x0, m0, w1, x1, m1, w2, x2, m2, w3, x3, m3;

  gray_updown_counter #(.NUMBER_OF_BITS(4)) d0 (
    .clk(clk), .rst(rst), .count_en(count_en), .up_dn(up_dn), .load(load),
    .load_val_b(lv), .g_count(g0), .b_count(b0), .g_next(n0), .wrap(w0),
    .at_max(x0), .at_min(m0));

  gray_updown_counter #(.NUMBER_OF_BITS(4), .SATURATE(1'b1)) d1 (
    .clk(clk), .rst(rst), .count_en(count_en), .up_dn(up_dn), .load(load),
    .load_val_b(lv), .g_count(g1), .b_count(b1), .g_next(n1), .wrap(w1),
    .at_max(x1), .at_min(m1));

  gray_updown_counter #(.NUMBER_OF_BITS(4), .RESET_VAL_G(4'b0011)) d2 (
    .clk(clk), .rst(rst), .count_en(count_en), .up_dn(up_dn), .load(load),
    .load_val_b(lv), .g_count(g2), .b_count(b2), .g_next(n2), .wrap(w2),
    .at_max(x2), .at_min(m2));

  gray_updown_counter #(.NUMBER_OF_BITS(2)) d3 (
    .clk(clk), .rst(rst), .count_en(count_en), .up_dn(up_dn), .load(load),
    .load_val_b(lv[1:0]), .g_count(g3), .b_count(b3), .g_next(n3), .wrap(w3),
    .at_max(x3), .at_min(m3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers per configuration
  int W[NI]    = '{4, 4, 4, 2};
  bit SATM[NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int RG[NI]   = '{0, 0, 3, 0};

  int mb[NI];
  bit mw[NI];
  bit stepped[NI];
  bit mvalid = 1'b0;

  function automatic int rst_bin(input int k);
    for (int v = 0; v < (1 << W[k]); v++) begin
      if ((v ^ (v >> 1)) == RG[k]) return v;
    end
    return -1;
  endfunction

  function automatic void model_next(input int k, input int b, output int nb, output bit nw);
    int span;
    span = 1 << W[k];
    nb = b;
    nw = 1'b0;
    if (rst) begin
      nb = rst_bin(k);
    end else if (load) begin
      nb = int'(lv) % span;
    end else if (count_en) begin
      if (up_dn) begin
        if (b + 1 >= span) begin
          if (!SATM[k]) begin nb = 0; nw = 1'b1; end
        end else nb = b + 1;
      end else begin
        if (b - 1 < 0) begin
          if (!SATM[k]) begin nb = span - 1; nw = 1'b1; end
        end else nb = b - 1;
      end
    end
  endfunction

  int u_nb;
  bit u_nw;
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      model_next(k, mb[k], u_nb, u_nw);
      stepped[k] = !rst && !load && count_en && (u_nb != mb[k]);
      mb[k] = u_nb;
      mw[k] = u_nw;
    end
    if (rst) mvalid = 1'b1;
  end

  // Compare process: registered outputs and look-ahead outputs every cycle
  logic [3:0] g_a[NI], b_a[NI], n_a[NI];
  logic       w_a[NI], x_a[NI], m_a[NI];
  logic [3:0] prev_g[NI];
  int  c_nb;
  bit  c_nw;

  always @(negedge clk) begin
    g_a = '{g0, g1, g2, {2'b00, g3}};
    b_a = '{b0, b1, b2, {2'b00, b3}};
    n_a = '{n0, n1, n2, {2'b00, n3}};
    w_a = '{w0, w1, w2, w3};
    x_a = '{x0, x1, x2, x3};
    m_a = '{m0, m1, m2, m3};
    if (mvalid) begin
      for (int k = 0; k < NI; k++) begin
        model_next(k, mb[k], c_nb, c_nw);
        chk($sformatf("b_count[%0d]", k), 32'(b_a[k]), 32'(mb[k]));
        chk($sformatf("g_count[%0d]", k), 32'(g_a[k]), 32'(mb[k] ^ (mb[k] >> 1)));
        chk($sformatf("wrap[%0d]", k), 32'(w_a[k]), 32'(mw[k]));
        chk($sformatf("g_next[%0d]", k), 32'(n_a[k]), 32'(c_nb ^ (c_nb >> 1)));
        chk($sformatf("at_max[%0d]", k), 32'(x_a[k]), 32'(mb[k] == (1 << W[k]) - 1));
        chk($sformatf("at_min[%0d]", k), 32'(m_a[k]), 32'(mb[k] == 0));
        chk($sformatf("gray_consistent[%0d]", k), 32'(g_a[k]), 32'(b_a[k] ^ (b_a[k] >> 1)));
        if (stepped[k])
          chk($sformatf("single_step[%0d]", k), 32'($countones(g_a[k] ^ prev_g[k])), 32'd1);
        prev_g[k] = g_a[k];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] gtbl[18] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                           4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                           4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    rst = 1'b1; count_en = 1'b0; up_dn = 1'b0; load = 1'b0; lv = '0;

    // Reset then count up across the wrap
    step();
    chk("rst_g0", 32'(g0), 32'd0);
    chk("rst_b0", 32'(b0), 32'd0);
    chk("rst_w0", 32'(w0), 32'd0);
    chk("rst_g2", 32'(g2), 32'b0011);
    chk("rst_b2", 32'(b2), 32'd2);
    rst = 1'b0; count_en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("up_g0_%0d", i), 32'(g0), 32'(gtbl[i]));
      chk($sformatf("up_w0_%0d", i), 32'(w0), 32'(i == 16));
    end

    // Count down through zero
    rst = 1'b1; count_en = 1'b0;
    step();
    rst = 1'b0; count_en = 1'b1; up_dn = 1'b0;
    step();
    chk("dn_b0_a", 32'(b0), 32'd15);
    chk("dn_g0_a", 32'(g0), 32'b1000);
    chk("dn_w0_a", 32'(w0), 32'd1);
    step();
    chk("dn_b0_b", 32'(b0), 32'd14);
    chk("dn_g0_b", 32'(g0), 32'b1001);
    chk("dn_w0_b", 32'(w0), 32'd0);

    // Load beats count
    load = 1'b1; lv = 4'd9; count_en = 1'b1; up_dn = 1'b1;
    #1;
    chk("ld_gnext0", 32'(n0), 32'b1101);
    step();
    load = 1'b0; count_en = 1'b0;
    chk("ld_b0", 32'(b0), 32'd9);
    chk("ld_g0", 32'(g0), 32'b1101);
    chk("ld_w0", 32'(w0), 32'd0);

    // Saturation at both ends
    load = 1'b1; lv = 4'd15;
    step();
    load = 1'b0; count_en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_b1_hi", 32'(b1), 32'd15);
      chk("sat_max1", 32'(x1), 32'd1);
      chk("sat_w1_hi", 32'(w1), 32'd0);
    end
    load = 1'b1; lv = 4'd0; count_en = 1'b0;
    step();
    load = 1'b0; count_en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_b1_lo", 32'(b1), 32'd0);
      chk("sat_min1", 32'(m1), 32'd1);
      chk("sat_w1_lo", 32'(w1), 32'd0);
    end

    // Reset mid-count overrides load, non-zero reset value
    load = 1'b1; lv = 4'd7; count_en = 1'b0;
    step();
    load = 1'b0; count_en = 1'b1; up_dn = 1'b1;
    chk("mid_b2_pre", 32'(b2), 32'd7);
    rst = 1'b1; load = 1'b1; lv = 4'd5;
    #1;
    chk("mid_gnext2", 32'(n2), 32'b0011);
    step();
    chk("mid_g2", 32'(g2), 32'b0011);
    chk("mid_b2", 32'(b2), 32'd2);
    chk("mid_w2", 32'(w2), 32'd0);
    rst = 1'b0; load = 1'b0;

    // Back-to-back wraps on the 2-bit counter
    rst = 1'b1; count_en = 1'b0;
    step();
    rst = 1'b0; count_en = 1'b1; up_dn = 1'b0;
    step();
    chk("b2b_b3_a", 32'(b3), 32'd3);
    chk("b2b_w3_a", 32'(w3), 32'd1);
    up_dn = 1'b1;
    step();
    chk("b2b_b3_b", 32'(b3), 32'd0);
    chk("b2b_w3_b", 32'(w3), 32'd1);
    up_dn = 1'b0;
    step();
    chk("b2b_b3_c", 32'(b3), 32'd3);
    chk("b2b_w3_c", 32'(w3), 32'd1);
    count_en = 1'b0;
    step();
    chk("b2b_w3_d", 32'(w3), 32'd0);

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      rst      = ($urandom_range(63) == 0);
      load     = ($urandom_range(15) == 0);
      count_en = ($urandom_range(3) != 0);
      up_dn    = $urandom_range(1) != 0;
      lv       = 4'($urandom);
      step();
    end
    rst = 1'b0; load = 1'b0; count_en = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
